// File: rtl/sysu_mux151_scan_arbiter.sv
// Round-robin arbiter that scans eight requests through an external 74LS151 mux.
// Optional forced release after HOLD_MAX grant cycles when SYSU_ARB_TIMEOUT_EN is defined.
module sysu_mux151_scan_arbiter #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned HOLD_MAX   = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       Q,
    input  logic       DONE,
    output logic       A2,
    output logic       A1,
    output logic       A0,
    output logic       S_n,
    output logic       GNT_VALID,
    output logic [2:0] GNT_IDX,
    output logic       SWEEP_EMPTY,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        GRANT
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] miss_q, miss_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] a_q, a_d;
    logic       s_n_q, s_n_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       sweep_q, sweep_d;
    logic       do_release;
    logic [2:0] next_ptr;

`ifdef SYSU_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`else
    logic [7:0] unused_hold_max;
    assign unused_hold_max = 8'(HOLD_MAX);
`endif

    assign next_ptr = gnt_idx_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        miss_d      = miss_q;
        settle_d    = settle_q;
        a_d         = a_q;
        s_n_d       = s_n_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        sweep_d     = 1'b0;
        do_release  = 1'b0;
`ifdef SYSU_ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        // Dropping EN aborts everything, but a DONE in the same cycle still rotates priority.
        if (!EN) begin
            state_d     = IDLE;
            s_n_d       = 1'b1;
            gnt_valid_d = 1'b0;
            miss_d      = 3'd0;
            settle_d    = 4'd0;
            if (state_q == GRANT && DONE) begin
                ptr_d = next_ptr;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    a_d      = ptr_q;
                    s_n_d    = 1'b0;
                    settle_d = 4'd0;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (Q) begin
                        state_d     = GRANT;
                        gnt_valid_d = 1'b1;
                        gnt_idx_d   = a_q;
                        miss_d      = 3'd0;
`ifdef SYSU_ARB_TIMEOUT_EN
                        hold_d      = 8'd0;
`endif
                    end else begin
                        state_d  = SETTLE;
                        ptr_d    = ptr_q + 3'd1;
                        a_d      = ptr_q + 3'd1;
                        settle_d = 4'd0;
                        if (miss_q == 3'd7) begin
                            sweep_d = 1'b1;
                            miss_d  = 3'd0;
                        end else begin
                            miss_d = miss_q + 3'd1;
                        end
                    end
                end
                GRANT: begin
                    if (DONE) begin
                        do_release = 1'b1;
                    end
`ifdef SYSU_ARB_TIMEOUT_EN
                    else if (hold_q == HOLD_LAST) begin
                        do_release = 1'b1;
                        timeout_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase

            // The released grantee becomes lowest priority for the next scan.
            if (do_release) begin
                state_d     = SETTLE;
                gnt_valid_d = 1'b0;
                ptr_d       = next_ptr;
                a_d         = next_ptr;
                settle_d    = 4'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            miss_q      <= 3'd0;
            settle_q    <= 4'd0;
            a_q         <= 3'd0;
            s_n_q       <= 1'b1;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= 3'd0;
            sweep_q     <= 1'b0;
`ifdef SYSU_ARB_TIMEOUT_EN
            hold_q      <= 8'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            miss_q      <= miss_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            s_n_q       <= s_n_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            sweep_q     <= sweep_d;
`ifdef SYSU_ARB_TIMEOUT_EN
            hold_q      <= hold_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign A2          = a_q[2];
    assign A1          = a_q[1];
    assign A0          = a_q[0];
    assign S_n         = s_n_q;
    assign GNT_VALID   = gnt_valid_q;
    assign GNT_IDX     = gnt_idx_q;
    assign SWEEP_EMPTY = sweep_q;
`ifdef SYSU_ARB_TIMEOUT_EN
    assign TIMEOUT     = timeout_q;
`else
    assign TIMEOUT     = 1'b0;
`endif

endmodule

// File: tb/tb_sysu_mux151_scan_arbiter.sv
// Scoreboard bench for sysu_mux151_scan_arbiter with a behavioural 74LS151 model on Q.
// Timeout scenario is built only when SYSU_ARB_TIMEOUT_EN is defined.
module tb_sysu_mux151_scan_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       DONE = 1'b0;
    logic       Q;
    logic [7:0] req = 8'h00;
    logic       A2, A1, A0, S_n, GNT_VALID, SWEEP_EMPTY, TIMEOUT;
    logic [2:0] GNT_IDX;
    logic [2:0] a_obs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] idx;
        int         lat;
    } grant_t;

    typedef struct {
        logic [2:0] a;
        logic       sweep;
    } scan_t;

    grant_t grant_q[$];
    scan_t  scan_q[$];

    sysu_mux151_scan_arbiter #(
        .SETTLE_CYC(1),
        .HOLD_MAX  (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .Q          (Q),
        .DONE       (DONE),
        .A2         (A2),
        .A1         (A1),
        .A0         (A0),
        .S_n        (S_n),
        .GNT_VALID  (GNT_VALID),
        .GNT_IDX    (GNT_IDX),
        .SWEEP_EMPTY(SWEEP_EMPTY),
        .TIMEOUT    (TIMEOUT)
    );

    // 74LS151: strobe high forces the output low, otherwise the addressed input passes.
    assign a_obs = {A2, A1, A0};
    assign Q     = ~S_n & req[a_obs];

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        RST  = 1'b1;
        EN   = 1'b0;
        DONE = 1'b0;
        req  = 8'h00;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_grant(input int start, output int cycles);
        cycles = start;
        while (!GNT_VALID && cycles <= 40) begin
            @(negedge CLK);
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_obs, S_n, GNT_VALID, GNT_IDX, SWEEP_EMPTY, TIMEOUT} !== {3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got A=%b S_n=%b V=%b IDX=%0d SW=%b TO=%b, expected A=000 S_n=1 V=0 IDX=0 SW=0 TO=0",
                     a_obs, S_n, GNT_VALID, GNT_IDX, SWEEP_EMPTY, TIMEOUT);
        end
    endtask

    task automatic test_sweep_empty();
        scan_t exp;
        do_reset();
        DONE = 1'b1;
        EN   = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            exp.a     = 3'(((i - 1) / 2) % 8);
            exp.sweep = (i == 17 || i == 33);
            scan_q.push_back(exp);
        end
        while (scan_q.size() > 0) begin
            @(negedge CLK);
            exp = scan_q.pop_front();
            checks++;
            if (a_obs !== exp.a || S_n !== 1'b0 || GNT_VALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sweep_addr: got A=%0d S_n=%b V=%b, expected A=%0d S_n=0 V=0", a_obs, S_n, GNT_VALID, exp.a);
            end
            checks++;
            if (SWEEP_EMPTY !== exp.sweep) begin
                errors++;
                $display("[TB] FAIL sweep_pulse: got %b at A=%0d, expected %b", SWEEP_EMPTY, a_obs, exp.sweep);
            end
        end
        DONE = 1'b0;
    endtask

    task automatic test_round_robin();
        grant_t exp;
        int     lat;
        do_reset();
        req = 8'b0010_1000;
        grant_q.push_back('{3'd3, 9});
        grant_q.push_back('{3'd5, 5});
        grant_q.push_back('{3'd3, 13});
        EN = 1'b1;
        wait_grant(0, lat);
        for (int n = 0; n < 3; n++) begin
            exp = grant_q.pop_front();
            checks++;
            if (GNT_VALID !== 1'b1 || GNT_IDX !== exp.idx || a_obs !== exp.idx) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got V=%b IDX=%0d A=%0d, expected V=1 IDX=%0d A=%0d", n, GNT_VALID, GNT_IDX, a_obs, exp.idx, exp.idx);
            end
            checks++;
            if (lat !== exp.lat) begin
                errors++;
                $display("[TB] FAIL rr_latency%0d: got %0d cycles, expected %0d", n, lat, exp.lat);
            end
            if (n < 2) begin
                DONE = 1'b1;
                @(negedge CLK);
                DONE = 1'b0;
                checks++;
                if (GNT_VALID !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rr_release%0d: got V=%b, expected 0", n, GNT_VALID);
                end
                wait_grant(1, lat);
            end
        end
    endtask

    task automatic test_request_drop();
        int lat;
        do_reset();
        req = 8'b0100_0000;
        EN  = 1'b1;
        wait_grant(0, lat);
        checks++;
        if (lat !== 15 || GNT_IDX !== 3'd6) begin
            errors++;
            $display("[TB] FAIL drop_grant: got lat=%0d IDX=%0d, expected lat=15 IDX=6", lat, GNT_IDX);
        end
        req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (GNT_VALID !== 1'b1 || GNT_IDX !== 3'd6 || a_obs !== 3'd6 || S_n !== 1'b0 || TIMEOUT !== 1'b0) begin
                errors++;
                $display("[TB] FAIL drop_hold: got V=%b IDX=%0d A=%0d S_n=%b TO=%b, expected V=1 IDX=6 A=6 S_n=0 TO=0",
                         GNT_VALID, GNT_IDX, a_obs, S_n, TIMEOUT);
            end
        end
        DONE = 1'b1;
        @(negedge CLK);
        DONE = 1'b0;
        req  = 8'h01;
        checks++;
        if (GNT_VALID !== 1'b0 || GNT_IDX !== 3'd6 || a_obs !== 3'd7 || TIMEOUT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_release: got V=%b IDX=%0d A=%0d TO=%b, expected V=0 IDX=6 A=7 TO=0", GNT_VALID, GNT_IDX, a_obs, TIMEOUT);
        end
        wait_grant(1, lat);
        checks++;
        if (lat !== 5 || GNT_IDX !== 3'd0) begin
            errors++;
            $display("[TB] FAIL wrap_grant: got lat=%0d IDX=%0d, expected lat=5 IDX=0", lat, GNT_IDX);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (GNT_VALID !== 1'b0 || S_n !== 1'b1 || a_obs !== 3'd0 || TIMEOUT !== 1'b0 || SWEEP_EMPTY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_grant: got V=%b S_n=%b A=%0d TO=%b SW=%b, expected V=0 S_n=1 A=0 TO=0 SW=0",
                     GNT_VALID, S_n, a_obs, TIMEOUT, SWEEP_EMPTY);
        end
    endtask

    task automatic test_enable_abort();
        int lat;
        do_reset();
        req = 8'b0000_0100;
        EN  = 1'b1;
        wait_grant(0, lat);
        checks++;
        if (lat !== 7 || GNT_IDX !== 3'd2) begin
            errors++;
            $display("[TB] FAIL abort_grant: got lat=%0d IDX=%0d, expected lat=7 IDX=2", lat, GNT_IDX);
        end
        EN = 1'b0;
        @(negedge CLK);
        checks++;
        if (GNT_VALID !== 1'b0 || S_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_idle: got V=%b S_n=%b, expected V=0 S_n=1", GNT_VALID, S_n);
        end
        EN = 1'b1;
        @(negedge CLK);
        checks++;
        if (a_obs !== 3'd2 || S_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_resume: got A=%0d S_n=%b, expected A=2 S_n=0", a_obs, S_n);
        end
        wait_grant(1, lat);
        checks++;
        if (lat !== 3 || GNT_IDX !== 3'd2) begin
            errors++;
            $display("[TB] FAIL regrant: got lat=%0d IDX=%0d, expected lat=3 IDX=2", lat, GNT_IDX);
        end
        DONE = 1'b1;
        EN   = 1'b0;
        @(negedge CLK);
        checks++;
        if (GNT_VALID !== 1'b0 || S_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_en_idle: got V=%b S_n=%b, expected V=0 S_n=1", GNT_VALID, S_n);
        end
        DONE = 1'b0;
        EN   = 1'b1;
        @(negedge CLK);
        checks++;
        if (a_obs !== 3'd3 || S_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_en_ptr: got A=%0d S_n=%b, expected A=3 S_n=0", a_obs, S_n);
        end
    endtask

`ifdef SYSU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        do_reset();
        req = 8'b0000_0010;
        EN  = 1'b1;
        wait_grant(0, lat);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge CLK);
            checks++;
            if (GNT_VALID !== 1'b1 || TIMEOUT !== 1'b0 || GNT_IDX !== 3'd1) begin
                errors++;
                $display("[TB] FAIL timeout_hold%0d: got V=%b TO=%b IDX=%0d, expected V=1 TO=0 IDX=1", i, GNT_VALID, TIMEOUT, GNT_IDX);
            end
        end
        @(negedge CLK);
        checks++;
        if (GNT_VALID !== 1'b0 || TIMEOUT !== 1'b1 || a_obs !== 3'd2) begin
            errors++;
            $display("[TB] FAIL timeout_release: got V=%b TO=%b A=%0d, expected V=0 TO=1 A=2", GNT_VALID, TIMEOUT, a_obs);
        end
        @(negedge CLK);
        checks++;
        if (TIMEOUT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got TO=%b, expected 0", TIMEOUT);
        end
    endtask
`else
    task automatic test_no_timeout();
        int lat;
        do_reset();
        req = 8'b0000_0010;
        EN  = 1'b1;
        wait_grant(0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (GNT_VALID !== 1'b1 || TIMEOUT !== 1'b0 || GNT_IDX !== 3'd1) begin
                errors++;
                $display("[TB] FAIL no_timeout%0d: got V=%b TO=%b IDX=%0d, expected V=1 TO=0 IDX=1", i, GNT_VALID, TIMEOUT, GNT_IDX);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep_empty();
        test_round_robin();
        test_request_drop();
        test_enable_abort();
`ifdef SYSU_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
